// File: rtl/sram_port0_ctrl_if.sv
// rtl/sram_port0_ctrl_if.sv - request/response handshake bundle for sram_port0_ctrl
//
// Purpose: groups the client-side request channel (req_*) and the read
// response channel (rsp_*) of the SRAM port-0 controller.
// Ports (signals):
//   req_valid/req_ready      request handshake
//   req_we                   1 = write, 0 = read
//   req_addr/wdata/wmask     word address, write data, byte enables
//   rsp_valid/rsp_ready      read response handshake
//   rsp_rdata                read data
// Modports: master = client (drives requests), slave = controller.
interface sram_port0_ctrl_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [NUM_WMASKS-1:0] req_wmask;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_port0_ctrl.sv
// rtl/sram_port0_ctrl.sv - credit-gated controller for port 0 of a synchronous SRAM macro
//
// Purpose: accepts read/write requests, drives the macro port from flops,
// captures read data two edges after acceptance into a response FIFO and
// limits outstanding reads with a credit counter so the FIFO cannot overflow.
// Ports:
//   clk0    clock shared with the macro port 0
//   rst0    asynchronous reset, active-high
//   bus     sram_port0_ctrl_if.slave (req_* in, rsp_* out)
//   csb0    macro chip select, active-low
//   web0    macro write enable, active-low
//   wmask0  macro byte write mask
//   addr0   macro word address
//   din0    macro write data
//   dout0   macro read data (only valid in the capture window)
module sram_port0_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  clk0,
   input  logic                  rst0,
   sram_port0_ctrl_if.slave      bus,
   output logic                  csb0,
   output logic                  web0,
   output logic [NUM_WMASKS-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

   logic                  ready_q;
   logic                  accept;
   logic                  rd_accept;
   logic                  push;
   logic                  pop;
   logic [CW-1:0]         credit;
   logic [CW-1:0]         credit_next;
   logic [CW-1:0]         count;
   logic                  rd_vld1;
   logic                  rd_vld2;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign accept        = bus.req_valid & ready_q;
   assign rd_accept     = accept & ~bus.req_we;
   assign push          = rd_vld2;
   assign pop           = bus.rsp_valid & bus.rsp_ready;
   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = (count != '0);
   assign bus.rsp_rdata = fifo_mem[rd_ptr];

   // Credit covers reads in the macro pipeline plus FIFO entries.
   always_comb begin
      credit_next = credit;
      if (rd_accept && !pop) begin
         credit_next = credit + 1'b1;
      end else if (!rd_accept && pop) begin
         credit_next = credit - 1'b1;
      end
   end

   // req_ready is a flop computed from next-state credit, so it never
   // depends combinationally on req_valid or rsp_ready, and it stays low
   // until the first edge after reset release.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         credit  <= '0;
         ready_q <= 1'b0;
      end else begin
         credit  <= credit_next;
         ready_q <= (credit_next < DEPTH_C);
      end
   end

   // Macro port: every output is a flop loaded at the accepting edge, so the
   // macro samples the access one edge later. Idle cycles deselect the macro
   // and leave addr0/din0 unchanged.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         csb0   <= 1'b1;
         web0   <= 1'b1;
         wmask0 <= '0;
         addr0  <= '0;
         din0   <= '0;
      end else begin
         csb0   <= ~accept;
         web0   <= ~(accept & bus.req_we);
         wmask0 <= (accept & bus.req_we) ? bus.req_wmask : '0;
         if (accept) begin
            addr0 <= bus.req_addr;
         end
         if (accept && bus.req_we) begin
            din0 <= bus.req_wdata;
         end
      end
   end

   // rd_vld1 marks the macro sampling a read at the next edge; rd_vld2 marks
   // dout0 being valid at the edge after that, the only edge it is captured.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         rd_vld1 <= 1'b0;
         rd_vld2 <= 1'b0;
      end else begin
         rd_vld1 <= rd_accept;
         rd_vld2 <= rd_vld1;
      end
   end

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= dout0;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   // The credit limit makes this unreachable; it guards against a broken
   // credit path silently overwriting unread responses.
   always @(posedge clk0) begin
      if (!rst0) begin
         fifo_overflow: assert (!(push && !pop && count == DEPTH_C));
      end
   end
endmodule

// File: tb/tb_sram_port0_ctrl.sv
// tb/tb_sram_port0_ctrl.sv - scoreboard testbench for sram_port0_ctrl
module tb_sram_port0_ctrl;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int NW    = 4;
   localparam int DEPTH = 4;

   logic          clk0 = 1'b0;
   logic          rst0 = 1'b0;
   logic          csb0, web0;
   logic [NW-1:0] wmask0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0 = '0;

   sram_port0_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) bus ();

   sram_port0_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW), .RSP_DEPTH(DEPTH)) dut (
      .clk0   (clk0),
      .rst0   (rst0),
      .bus    (bus),
      .csb0   (csb0),
      .web0   (web0),
      .wmask0 (wmask0),
      .addr0  (addr0),
      .din0   (din0),
      .dout0  (dout0)
   );

   always #5 clk0 = ~clk0;

   // Behavioural macro: latches the port at posedge, writes or reads at the
   // following negedge, drives junk on dout0 when no read is in progress.
   logic [DW-1:0] macro_mem [1<<AW];
   logic          m_csb = 1'b1;
   logic          m_web = 1'b1;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_din = '0;
   logic [NW-1:0] m_mask = '0;

   always @(posedge clk0) begin
      m_csb  <= csb0;
      m_web  <= web0;
      m_addr <= addr0;
      m_din  <= din0;
      m_mask <= wmask0;
   end

   always @(negedge clk0) begin
      if (!m_csb && !m_web) begin
         for (int b = 0; b < NW; b++)
            if (m_mask[b]) macro_mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
      end
      if (!m_csb && m_web) dout0 <= macro_mem[m_addr];
      else                 dout0 <= $urandom;
   end

   // Reference model and scoreboard
   logic [DW-1:0] ref_mem [1<<AW];
   logic [DW-1:0] exp_q [$];
   int total = 0;
   int bad = 0;
   int acc_cnt = 0;
   int rsp_cnt = 0;
   int stalls = 0;

   always @(negedge clk0) begin
      if (!rst0) begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected: got %08h with nothing outstanding", bus.rsp_rdata);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               rsp_cnt++;
               if (bus.rsp_rdata !== e) begin
                  bad++;
                  $display("FAIL rsp_data: got %08h expected %08h", bus.rsp_rdata, e);
               end
            end
         end
         if (bus.req_valid && bus.req_ready) begin
            acc_cnt++;
            if (bus.req_we) begin
               for (int b = 0; b < NW; b++)
                  if (bus.req_wmask[b]) ref_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
            end else begin
               exp_q.push_back(ref_mem[bus.req_addr]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk0);
         #1;
      end
   endtask

   // Called at #1 after a posedge; returns at #1 after the accepting edge.
   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NW-1:0] m);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wmask = m;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk0);
         if (bus.req_ready) begin
            @(posedge clk0);
            #1;
            bus.req_valid = 1'b0;
            return;
         end
         stalls++;
         @(posedge clk0);
         #1;
      end
      bus.req_valid = 1'b0;
      chk("issue_timeout", 64'd1, 64'd0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_csb0", csb0, 1);
      chk("rst_web0", web0, 1);
      chk("rst_wmask0", wmask0, 0);
      chk("rst_addr0", addr0, 0);
      chk("rst_din0", din0, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int r0;
      int csb_low;
      int vld_seen;
      logic acc;

      for (int i = 0; i < (1 << AW); i++) begin
         logic [DW-1:0] v;
         v = $urandom;
         macro_mem[i] = v;
         ref_mem[i] = v;
      end
      bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0;
      bus.req_wdata = 0; bus.req_wmask = 0; bus.rsp_ready = 0;

      #1 rst0 = 1'b1;
      tick(3);
      chk_reset_vals();
      rst0 = 1'b0;
      chk("ready_before_first_edge", bus.req_ready, 0);
      tick(1);
      chk("ready_after_first_edge", bus.req_ready, 1);

      // Write then read 0x10, with port and latency checks
      issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
      chk("wr_csb0", csb0, 0);
      chk("wr_web0", web0, 0);
      chk("wr_wmask0", wmask0, 4'hF);
      chk("wr_din0", din0, 32'hDEADBEEF);
      issue(1'b0, 8'h10, 32'h0, 4'h0);
      chk("rd_csb0", csb0, 0);
      chk("rd_web0", web0, 1);
      chk("rd_wmask0", wmask0, 0);
      chk("rd_addr0", addr0, 8'h10);
      chk("rd_din0_held", din0, 32'hDEADBEEF);
      tick(1);
      chk("idle_csb0", csb0, 1);
      chk("idle_web0", web0, 1);
      chk("idle_addr0_held", addr0, 8'h10);
      chk("lat_not_yet", bus.rsp_valid, 0);
      tick(1);
      chk("lat_valid", bus.rsp_valid, 1);
      chk("lat_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      bus.rsp_ready = 1'b1;
      tick(3);

      // Partial byte-mask write
      bus.rsp_ready = 1'b0;
      issue(1'b1, 8'h20, 32'h11223344, 4'hF);
      issue(1'b1, 8'h20, 32'hAABBCCDD, 4'h5);
      issue(1'b0, 8'h20, 32'h0, 4'h0);
      tick(2);
      chk("mask_valid", bus.rsp_valid, 1);
      chk("mask_rdata", bus.rsp_rdata, 32'h11BB33DD);
      bus.rsp_ready = 1'b1;
      tick(3);

      // 64 back-to-back reads
      stalls = 0;
      r0 = rsp_cnt;
      for (int i = 0; i < 64; i++) issue(1'b0, AW'($urandom), 32'h0, 4'h0);
      chk("b2b_stalls", stalls, 0);
      tick(6);
      chk("b2b_rsp_count", rsp_cnt - r0, 64);

      // Credit limit with rsp_ready low, then a single-cycle pop
      bus.rsp_ready = 1'b0;
      a0 = acc_cnt;
      csb_low = 0;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h33;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (i >= 5 && !csb0) csb_low++;
      end
      chk("credit_accepts", acc_cnt - a0, 4);
      chk("credit_ready_low", bus.req_ready, 0);
      chk("credit_csb_idle", csb_low, 0);
      bus.rsp_ready = 1'b1;
      tick(1);
      bus.rsp_ready = 1'b0;
      tick(8);
      chk("credit_one_more", acc_cnt - a0, 5);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick(10);
      chk("credit_drained", exp_q.size(), 0);

      // Reset one cycle after a read accept
      issue(1'b0, 8'h44, 32'h0, 4'h0);
      tick(1);
      rst0 = 1'b1;
      exp_q.delete();
      #1;
      chk_reset_vals();
      tick(3);
      rst0 = 1'b0;
      chk("rerst_ready_low", bus.req_ready, 0);
      vld_seen = 0;
      tick(1);
      chk("rerst_ready_high", bus.req_ready, 1);
      for (int i = 0; i < 6; i++) begin
         if (bus.rsp_valid) vld_seen++;
         tick(1);
      end
      chk("rerst_no_late_rsp", vld_seen, 0);
      r0 = rsp_cnt;
      issue(1'b1, 8'h55, 32'hCAFEF00D, 4'hF);
      issue(1'b0, 8'h55, 32'h0, 4'h0);
      tick(5);
      chk("rerst_traffic", rsp_cnt - r0, 1);

      // Random mixed traffic
      acc = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (!bus.req_valid || acc) begin
            if ($urandom_range(0, 3) != 0) begin
               bus.req_valid = 1'b1;
               bus.req_we    = $urandom_range(0, 1) == 1;
               bus.req_addr  = AW'($urandom_range(0, 15));
               bus.req_wdata = $urandom;
               bus.req_wmask = NW'($urandom);
            end else begin
               bus.req_valid = 1'b0;
            end
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk0);
         acc = bus.req_valid && bus.req_ready;
         @(posedge clk0);
         #1;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick(12);
      chk("final_drained", exp_q.size(), 0);
      chk("final_rsp_valid", bus.rsp_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
